// File: rtl/mastermind_round_ctrl.sv
// Mastermind round sequencer: code/guess entry on LOAD rises, clear + 4 compares + settle + judge (scores at T+8).
// Define MM_GUESS_LIMIT_EN to enable the guess limit (LOST); otherwise guess_count saturates and LOST is unreachable.
module mastermind_round_ctrl #(
  parameter int MAX_GUESSES = 8,
  parameter int GC_W        = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic [2:0]      red_in,
  input  logic [2:0]      white_in,
  output logic [3:0]      load_code,
  output logic [3:0]      load_guess,
  output logic            clr_score,
  output logic            cmp_en,
  output logic [1:0]      cmp_idx,
  output logic [2:0]      score_red,
  output logic [2:0]      score_white,
  output logic [GC_W-1:0] guess_count,
  output logic            game_won,
  output logic            game_lost
);

  typedef enum logic [2:0] {
    S_CODE_SEL, S_GUESS_SEL, S_CLEAR, S_CMP, S_SETTLE, S_JUDGE, S_WON, S_LOST
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_pos, w_pos_nxt;
  logic            r_load_q;
  logic [2:0]      r_score_red, r_score_white;
  logic [GC_W-1:0] r_guess_count;
  logic            r_won, r_lost;

  logic            w_load_rise;
  logic [GC_W:0]   w_gc_inc;
  logic [GC_W-1:0] w_gc_judged;
  logic            w_judge_won, w_judge_lost;
  logic            w_restart;

  assign w_load_rise = load & ~r_load_q;
  assign w_gc_inc    = {1'b0, r_guess_count} + {{GC_W{1'b0}}, 1'b1};
  assign w_judge_won = (red_in == 3'd4);
  assign w_restart   = ((r_state == S_WON) || (r_state == S_LOST)) && w_load_rise;

`ifdef MM_GUESS_LIMIT_EN
  assign w_judge_lost = ~w_judge_won & (w_gc_inc == (GC_W+1)'(MAX_GUESSES));
  assign w_gc_judged  = w_gc_inc[GC_W-1:0];
`else
  assign w_judge_lost = 1'b0;
  // Hold at all-ones instead of wrapping to zero.
  assign w_gc_judged  = w_gc_inc[GC_W] ? r_guess_count : w_gc_inc[GC_W-1:0];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_CODE_SEL;
      r_pos   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    load_code   = 4'b0000;
    load_guess  = 4'b0000;
    clr_score   = 1'b0;
    cmp_en      = 1'b0;
    cmp_idx     = 2'd0;
    case (r_state)
      S_CODE_SEL: begin
        if (w_load_rise) begin
          load_code[r_pos] = 1'b1;
          w_pos_nxt        = r_pos + 2'd1;
          if (r_pos == 2'd3) w_state_nxt = S_GUESS_SEL;
        end
      end
      S_GUESS_SEL: begin
        if (w_load_rise) begin
          load_guess[r_pos] = 1'b1;
          w_pos_nxt         = r_pos + 2'd1;
          if (r_pos == 2'd3) w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_score   = 1'b1;
        w_pos_nxt   = 2'd0;
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
        cmp_en    = 1'b1;
        cmp_idx   = r_pos;
        w_pos_nxt = r_pos + 2'd1;
        if (r_pos == 2'd3) w_state_nxt = S_SETTLE;
      end
      // Scorer output is registered; one idle cycle lets the idx-3 update land.
      S_SETTLE: w_state_nxt = S_JUDGE;
      S_JUDGE: begin
        w_pos_nxt = 2'd0;
        if (w_judge_won)       w_state_nxt = S_WON;
        else if (w_judge_lost) w_state_nxt = S_LOST;
        else                   w_state_nxt = S_GUESS_SEL;
      end
      S_WON, S_LOST: begin
        if (w_load_rise) begin
          w_pos_nxt   = 2'd0;
          w_state_nxt = S_CODE_SEL;
        end
      end
      default: begin
        w_pos_nxt   = 2'd0;
        w_state_nxt = S_CODE_SEL;
      end
    endcase
  end

  // load_q resets high so a button held through reset produces no rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_load_q      <= 1'b1;
      r_score_red   <= 3'd0;
      r_score_white <= 3'd0;
      r_guess_count <= '0;
      r_won         <= 1'b0;
      r_lost        <= 1'b0;
    end else begin
      r_load_q <= load;
      if (r_state == S_JUDGE) begin
        r_score_red   <= red_in;
        r_score_white <= white_in;
        r_guess_count <= w_gc_judged;
        r_won         <= w_judge_won;
        r_lost        <= w_judge_lost;
      end else if (w_restart) begin
        r_score_red   <= 3'd0;
        r_score_white <= 3'd0;
        r_guess_count <= '0;
        r_won         <= 1'b0;
        r_lost        <= 1'b0;
      end
    end
  end

  assign score_red   = r_score_red;
  assign score_white = r_score_white;
  assign guess_count = r_guess_count;
  assign game_won    = r_won;
  assign game_lost   = r_lost;

endmodule
